// File: rtl/hitmem_layer_addr_mgr.sv
// Per-layer hit-memory address manager: saturating write counters with status
// flags, plus a read sequencer that walks one layer's stored addresses.
module hitmem_layer_addr_mgr #(
  parameter int NLAYERS = 6,
  parameter int LAYER_W = 3,
  parameter int ADDR_W  = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               wr_valid,
  input  logic [LAYER_W-1:0] wr_layer,
  output logic               wr_accept,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [NLAYERS-1:0] full,
  output logic [NLAYERS-1:0] empty,
  output logic [NLAYERS-1:0] ovf,
  input  logic               rd_start,
  input  logic [LAYER_W-1:0] rd_layer,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic               rd_last,
  output logic               rd_busy,
  output logic               rd_done
);

  localparam logic [ADDR_W:0]  DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [LAYER_W:0] NL_C    = (LAYER_W+1)'(NLAYERS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  logic [ADDR_W:0]    count_q [NLAYERS];
  logic [ADDR_W:0]    count_d [NLAYERS];
  logic [NLAYERS-1:0] ovf_q, ovf_d;
  state_t             state_q, state_d;
  logic [ADDR_W:0]    len_q, len_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;

  logic               wr_legal, rd_legal, idx_is_last;
  logic [ADDR_W:0]    wr_cnt, rd_cnt;

  // Variable-layer lookups use a compare loop so an illegal layer reads as 0
  always_comb begin
    wr_cnt = '0;
    rd_cnt = '0;
    for (int i = 0; i < NLAYERS; i++) begin
      if (wr_layer == LAYER_W'(i)) wr_cnt = count_q[i];
      if (rd_layer == LAYER_W'(i)) rd_cnt = count_q[i];
    end
  end

  assign wr_legal  = {1'b0, wr_layer} < NL_C;
  assign rd_legal  = {1'b0, rd_layer} < NL_C;
  assign wr_accept = wr_valid & ~clear & wr_legal & (wr_cnt != DEPTH_C);
  assign wr_addr   = wr_cnt[ADDR_W-1:0];

  always_comb begin
    for (int i = 0; i < NLAYERS; i++) begin
      full[i]  = (count_q[i] == DEPTH_C);
      empty[i] = (count_q[i] == '0);
    end
  end

  assign ovf = ovf_q;

  always_comb begin
    ovf_d = ovf_q;
    for (int i = 0; i < NLAYERS; i++) count_d[i] = count_q[i];
    if (clear) begin
      ovf_d = '0;
      for (int i = 0; i < NLAYERS; i++) count_d[i] = '0;
    end else if (wr_valid && wr_legal) begin
      for (int i = 0; i < NLAYERS; i++) begin
        if (wr_layer == LAYER_W'(i)) begin
          if (count_q[i] != DEPTH_C) count_d[i] = count_q[i] + 1'b1;
          else                       ovf_d[i]   = 1'b1;
        end
      end
    end
  end

  // len may equal DEPTH, so compare in ADDR_W+1 bits
  assign idx_is_last = ({1'b0, idx_q} == (len_q - 1'b1));

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (rd_start) begin
          len_d   = rd_legal ? rd_cnt : '0;
          idx_d   = '0;
          state_d = (rd_legal && rd_cnt != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (rd_ready) begin
          if (idx_is_last) state_d = S_DONE;
          else             idx_d   = idx_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (clear) state_d = S_IDLE;
  end

  assign rd_valid = (state_q == S_RUN);
  assign rd_last  = rd_valid & idx_is_last;
  assign rd_done  = (state_q == S_DONE);
  assign rd_busy  = (state_q != S_IDLE);
  assign rd_addr  = idx_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      ovf_q   <= '0;
      for (int i = 0; i < NLAYERS; i++) count_q[i] <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < NLAYERS; i++) count_q[i] <= count_d[i];
    end
  end

endmodule

// File: tb/tb_hitmem_layer_addr_mgr.sv
// Bench for hitmem_layer_addr_mgr: directed vector table, corner-case sequences
// and randomized traffic against a behavioural model.
module tb_hitmem_layer_addr_mgr;
  localparam int NL = 6, LW = 3, AW = 5, DEPTH = 32;

  logic          clock = 1'b0;
  logic          reset, clear, wr_valid, rd_start, rd_ready;
  logic [LW-1:0] wr_layer, rd_layer;
  logic          wr_accept, rd_valid, rd_last, rd_busy, rd_done;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [NL-1:0] full, empty, ovf;

  hitmem_layer_addr_mgr #(.NLAYERS(NL), .LAYER_W(LW), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .wr_valid(wr_valid), .wr_layer(wr_layer), .wr_accept(wr_accept), .wr_addr(wr_addr),
    .full(full), .empty(empty), .ovf(ovf),
    .rd_start(rd_start), .rd_layer(rd_layer), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_addr(rd_addr), .rd_last(rd_last), .rd_busy(rd_busy), .rd_done(rd_done)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_err = 0;

  // Reference model: hit counts per layer, sticky overflow, and the read pass
  // as "phase + position within a snapshot length".
  int cnt [8];
  bit [7:0] movf;
  int rphase, pos, plen;  // rphase: 0 idle, 1 reading, 2 finishing

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic [NL-1:0] ef, ee, eo;
    bit legal;
    legal = (wr_layer < NL);
    for (int i = 0; i < NL; i++) begin
      ef[i] = (cnt[i] == DEPTH);
      ee[i] = (cnt[i] == 0);
      eo[i] = movf[i];
    end
    chk("m_wr_accept", wr_accept, 32'(wr_valid && !clear && legal && cnt[wr_layer] < DEPTH));
    if (wr_valid && legal) chk("m_wr_addr", wr_addr, cnt[wr_layer] % DEPTH);
    chk("m_full", full, ef);
    chk("m_empty", empty, ee);
    chk("m_ovf", ovf, eo);
    chk("m_rd_valid", rd_valid, 32'(rphase == 1));
    chk("m_rd_busy", rd_busy, 32'(rphase != 0));
    chk("m_rd_done", rd_done, 32'(rphase == 2));
    if (rphase == 1) begin
      chk("m_rd_addr", rd_addr, pos);
      chk("m_rd_last", rd_last, 32'(pos == plen - 1));
    end
  endtask

  task automatic model_step();
    if (clear) begin
      for (int i = 0; i < 8; i++) cnt[i] = 0;
      movf = '0;
      rphase = 0;
    end else begin
      if (rphase == 0 && rd_start) begin
        plen = (rd_layer < NL) ? cnt[rd_layer] : 0;
        pos = 0;
        rphase = (plen == 0) ? 2 : 1;
      end else if (rphase == 1 && rd_ready) begin
        if (pos == plen - 1) rphase = 2;
        else pos++;
      end else if (rphase == 2) begin
        rphase = 0;
      end
      if (wr_valid && wr_layer < NL) begin
        if (cnt[wr_layer] < DEPTH) cnt[wr_layer]++;
        else movf[wr_layer] = 1'b1;
      end
    end
  endtask

  task automatic drive(input logic c, input logic wv, input logic [LW-1:0] wl,
                       input logic rs, input logic [LW-1:0] rl, input logic rr);
    clear = c; wr_valid = wv; wr_layer = wl;
    rd_start = rs; rd_layer = rl; rd_ready = rr;
    @(negedge clock);
    model_check();
  endtask

  task automatic adv();
    @(posedge clock);
    model_step();
    #1;
  endtask

  typedef struct {
    logic clr, wv; logic [LW-1:0] wl; logic rs; logic [LW-1:0] rl; logic rr;
    logic acc; logic [AW-1:0] wa; logic rv; logic [AW-1:0] ra; logic last, done, busy;
  } vec_t;
  vec_t tbl [20];

  initial begin
    //            clr  wv   wl   rs   rl   rr  | acc  wa   rv   ra  last done busy
    tbl[0]  = '{1'b0,1'b1,3'd2,1'b0,3'd0,1'b0, 1'b1,5'd0,1'b0,5'd0,1'b0,1'b0,1'b0};
    tbl[1]  = '{1'b0,1'b1,3'd2,1'b0,3'd0,1'b0, 1'b1,5'd1,1'b0,5'd0,1'b0,1'b0,1'b0};
    tbl[2]  = '{1'b0,1'b1,3'd2,1'b0,3'd0,1'b0, 1'b1,5'd2,1'b0,5'd0,1'b0,1'b0,1'b0};
    tbl[3]  = '{1'b0,1'b1,3'd0,1'b0,3'd0,1'b0, 1'b1,5'd0,1'b0,5'd0,1'b0,1'b0,1'b0};
    tbl[4]  = '{1'b0,1'b1,3'd3,1'b0,3'd0,1'b0, 1'b1,5'd0,1'b0,5'd0,1'b0,1'b0,1'b0};
    tbl[5]  = '{1'b0,1'b1,3'd3,1'b0,3'd0,1'b0, 1'b1,5'd1,1'b0,5'd0,1'b0,1'b0,1'b0};
    tbl[6]  = '{1'b0,1'b1,3'd3,1'b0,3'd0,1'b0, 1'b1,5'd2,1'b0,5'd0,1'b0,1'b0,1'b0};
    tbl[7]  = '{1'b0,1'b1,3'd3,1'b0,3'd0,1'b0, 1'b1,5'd3,1'b0,5'd0,1'b0,1'b0,1'b0};
    tbl[8]  = '{1'b0,1'b0,3'd0,1'b1,3'd3,1'b0, 1'b0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b0};
    tbl[9]  = '{1'b0,1'b0,3'd0,1'b0,3'd0,1'b1, 1'b0,5'd0,1'b1,5'd0,1'b0,1'b0,1'b1};
    tbl[10] = '{1'b0,1'b0,3'd0,1'b0,3'd0,1'b0, 1'b0,5'd0,1'b1,5'd1,1'b0,1'b0,1'b1};
    tbl[11] = '{1'b0,1'b0,3'd0,1'b0,3'd0,1'b1, 1'b0,5'd0,1'b1,5'd1,1'b0,1'b0,1'b1};
    tbl[12] = '{1'b0,1'b0,3'd0,1'b0,3'd0,1'b1, 1'b0,5'd0,1'b1,5'd2,1'b0,1'b0,1'b1};
    tbl[13] = '{1'b0,1'b0,3'd0,1'b0,3'd0,1'b0, 1'b0,5'd0,1'b1,5'd3,1'b1,1'b0,1'b1};
    tbl[14] = '{1'b0,1'b0,3'd0,1'b0,3'd0,1'b1, 1'b0,5'd0,1'b1,5'd3,1'b1,1'b0,1'b1};
    tbl[15] = '{1'b0,1'b0,3'd0,1'b0,3'd0,1'b0, 1'b0,5'd0,1'b0,5'd0,1'b0,1'b1,1'b1};
    tbl[16] = '{1'b0,1'b0,3'd0,1'b0,3'd0,1'b0, 1'b0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b0};
    tbl[17] = '{1'b0,1'b0,3'd0,1'b1,3'd4,1'b1, 1'b0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b0};
    tbl[18] = '{1'b0,1'b0,3'd0,1'b0,3'd0,1'b1, 1'b0,5'd0,1'b0,5'd0,1'b0,1'b1,1'b1};
    tbl[19] = '{1'b0,1'b0,3'd0,1'b0,3'd0,1'b1, 1'b0,5'd0,1'b0,5'd0,1'b0,1'b0,1'b0};

    for (int i = 0; i < 8; i++) cnt[i] = 0;
    movf = '0; rphase = 0; pos = 0; plen = 0;
    reset = 1'b1; clear = 1'b0; wr_valid = 1'b0; wr_layer = '0;
    rd_start = 1'b0; rd_layer = '0; rd_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_empty", empty, 6'b111111);
    chk("rst_full", full, 6'b0);
    chk("rst_ovf", ovf, 6'b0);
    chk("rst_rd_ctrl", {rd_valid, rd_last, rd_done, rd_busy}, 4'b0);
    chk("rst_rd_addr", rd_addr, 5'd0);

    // Directed table: layer 2/0 writes, fill layer 3, toggled-ready read, empty read
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].clr, tbl[i].wv, tbl[i].wl, tbl[i].rs, tbl[i].rl, tbl[i].rr);
      chk($sformatf("tv%0d_acc", i), wr_accept, tbl[i].acc);
      if (tbl[i].wv) chk($sformatf("tv%0d_waddr", i), wr_addr, tbl[i].wa);
      chk($sformatf("tv%0d_rvalid", i), rd_valid, tbl[i].rv);
      if (tbl[i].rv) begin
        chk($sformatf("tv%0d_raddr", i), rd_addr, tbl[i].ra);
        chk($sformatf("tv%0d_rlast", i), rd_last, tbl[i].last);
      end
      chk($sformatf("tv%0d_rdone", i), rd_done, tbl[i].done);
      chk($sformatf("tv%0d_rbusy", i), rd_busy, tbl[i].busy);
      adv();
      if (i == 3) begin
        chk("t1_empty", empty, 6'b111010);
        chk("t1_full", full, 6'b0);
      end
    end

    // Fill layer 1 past depth, then clear
    for (int k = 0; k < 33; k++) begin
      drive(1'b0, 1'b1, 3'd1, 1'b0, 3'd0, 1'b0);
      chk("ovf_acc", wr_accept, 32'(k < 32));
      if (k < 32) chk("ovf_addr", wr_addr, k);
      adv();
      if (k == 30) chk("ovf_notfull", full[1], 1'b0);
      if (k == 31) chk("ovf_full32", full[1], 1'b1);
    end
    chk("ovf_set", ovf, 6'b000010);
    chk("ovf_still_full", full[1], 1'b1);
    drive(1'b0, 1'b1, 3'd1, 1'b0, 3'd0, 1'b0);
    chk("ovf_refuse_again", wr_accept, 1'b0);
    adv();
    drive(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    adv();
    chk("clr_full", full[1], 1'b0);
    chk("clr_ovf", ovf[1], 1'b0);
    chk("clr_empty", empty, 6'b111111);

    // Snapshot: writes during RUN don't extend the pass
    repeat (2) begin drive(1'b0, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0); adv(); end
    drive(1'b0, 1'b0, 3'd0, 1'b1, 3'd0, 1'b0); adv();
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
      chk("snap_hold_addr", rd_addr, 5'd0);
      chk("snap_hold_valid", rd_valid, 1'b1);
      adv();
    end
    drive(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
    chk("snap_a0_last", rd_last, 1'b0); adv();
    drive(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
    chk("snap_a1", rd_addr, 5'd1);
    chk("snap_a1_last", rd_last, 1'b1); adv();
    drive(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
    chk("snap_done", rd_done, 1'b1); adv();
    // New pass with a same-cycle write excluded from the snapshot
    drive(1'b0, 1'b1, 3'd0, 1'b1, 3'd0, 1'b1);
    chk("snap2_wr_addr", wr_addr, 5'd7); adv();
    for (int k = 0; k < 7; k++) begin
      drive(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
      chk("snap2_addr", rd_addr, k);
      chk("snap2_last", rd_last, 32'(k == 6));
      adv();
    end
    drive(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
    chk("snap2_done", rd_done, 1'b1); adv();

    // Clear mid-RUN together with a write
    drive(1'b0, 1'b0, 3'd0, 1'b1, 3'd0, 1'b0); adv();
    drive(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1); adv();
    drive(1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b1);
    chk("cmr_acc", wr_accept, 1'b0); adv();
    drive(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
    chk("cmr_busy", rd_busy, 1'b0);
    chk("cmr_done", rd_done, 1'b0);
    chk("cmr_empty", empty, 6'b111111);
    adv();

    // Illegal layer write and read
    drive(1'b0, 1'b1, 3'd7, 1'b1, 3'd7, 1'b1);
    chk("ill_acc", wr_accept, 1'b0); adv();
    drive(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
    chk("ill_ovf", ovf, 6'b0);
    chk("ill_empty", empty, 6'b111111);
    chk("ill_rd_done", rd_done, 1'b1);
    adv();

    // Full-depth read on layer 5
    for (int k = 0; k < DEPTH; k++) begin drive(1'b0, 1'b1, 3'd5, 1'b0, 3'd0, 1'b0); adv(); end
    drive(1'b0, 1'b0, 3'd0, 1'b1, 3'd5, 1'b1); adv();
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
      chk("fd_addr", rd_addr, k);
      chk("fd_last", rd_last, 32'(k == DEPTH - 1));
      adv();
    end
    drive(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
    chk("fd_done", rd_done, 1'b1); adv();

    // Randomized traffic against the model
    for (int k = 0; k < 1500; k++) begin
      drive(1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 9) < 7),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 4) == 0),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 9) < 6));
      adv();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/hitmem_layer_addr_mgr.md
Name: hitmem_layer_addr_mgr

Overview:
- Per-layer hit-memory address manager for the GigaFitter hit buffer.
- Keeps an independent, saturating write counter for each detector layer and supplies the write address for each incoming hit.
- Provides full/empty/sticky-overflow status per layer.
- Contains a read sequencer that walks the stored addresses of one selected layer under a valid/ready handshake, for downstream combination building.

Parameters:
- NLAYERS, 6, number of layers/channels; legal range 1..2^LAYER_W.
- LAYER_W, 3, width of the layer select fields.
- ADDR_W, 5, address width; per-layer depth DEPTH = 2^ADDR_W.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- clear  in  1  start of new event; synchronous counter/status clear.
- wr_valid  in  1  hit write request.
- wr_layer  in  LAYER_W  layer of the hit.
- wr_accept  out  1  combinational; write accepted this cycle.
- wr_addr  out  ADDR_W  combinational; address for the hit (current count of wr_layer, low ADDR_W bits).
- full  out  NLAYERS  per-layer count == DEPTH.
- empty  out  NLAYERS  per-layer count == 0.
- ovf  out  NLAYERS  sticky; a write was refused because the layer was full.
- rd_start  in  1  start read of rd_layer; sampled only in IDLE.
- rd_layer  in  LAYER_W  layer to read.
- rd_valid  out  1  rd_addr is valid.
- rd_ready  in  1  consumer accepts rd_addr.
- rd_addr  out  ADDR_W  address being read.
- rd_last  out  1  qualifies rd_valid; final address of the layer.
- rd_busy  out  1  sequencer not IDLE.
- rd_done  out  1  one-cycle pulse at the end of a read pass.

Behaviour:
- Reset: all counters 0, empty all 1, full 0, ovf 0, FSM IDLE, rd_valid/rd_last/rd_done/rd_busy 0, rd_addr 0.
- Counters: ADDR_W+1 bits per layer, range 0..DEPTH, no wrap-around. Counts saturate at DEPTH.
- Write accept: wr_accept = wr_valid & ~clear & (wr_layer < NLAYERS) & ~full[wr_layer].
- On an accepted write, the counter of wr_layer increments at the next edge. wr_addr is the pre-increment count.
- Overflow: if wr_valid & ~clear & legal layer & full, then ovf[wr_layer] is set at the next edge. The count is unchanged. ovf stays set until clear or reset.
- Illegal layer (wr_layer >= NLAYERS): write ignored, no flag is set.
- clear: all counters are set to 0 and ovf to 0 at the next edge. clear takes priority over a same-cycle write. It also aborts the sequencer to IDLE with no rd_done pulse.
- Status flags full, empty and ovf are registered-state derived. They reflect a write one cycle after it is accepted.
- Sequencer FSM, states IDLE, RUN, DONE:
  - IDLE: rd_start & ~clear latches rd_layer and snapshots len = count[rd_layer]. A same-cycle write to that layer is excluded from the snapshot.
    - If len == 0, or rd_layer is illegal, go to DONE.
    - Otherwise set idx = 0 and go to RUN.
  - RUN: rd_valid = 1, rd_addr = idx, rd_last = (idx == len-1).
    - A handshake occurs when rd_valid & rd_ready. On a handshake that is not last, idx increments. On a handshake that is last, go to DONE.
    - With no handshake, rd_addr/rd_last are held stable.
  - DONE: rd_done = 1 for exactly one cycle, then go to IDLE. rd_busy = 1 in RUN and DONE.
- Writes during RUN are permitted. They never extend the current pass (snapshot semantics).
- rd_start outside IDLE is ignored.
- Latency: first rd_valid appears one cycle after rd_start. A full-depth pass with rd_ready held high takes DEPTH cycles in RUN plus one DONE cycle.
- len == DEPTH is legal: idx runs 0..DEPTH-1 and needs only ADDR_W bits.

Test Plan:
- Reset, then 3 writes to layer 2 and 1 write to layer 0 -> wr_addr sequence 0,1,2 on layer 2 and 0 on layer 0. empty = 6'b111010, full = 0.
- 33 writes to layer 1 (ADDR_W=5) -> first 32 accepted with addresses 0..31, full[1] = 1 after the 32nd. 33rd has wr_accept = 0, ovf[1] = 1, count stays 32. A following clear -> full[1] = 0, ovf[1] = 0, empty[1] = 1.
- Layer 3 holds 4 hits; rd_start with rd_ready toggling 1,0,1,1,0,1 -> rd_addr 0,1,1,2,3,3 with rd_last only at addr 3. One-cycle rd_done after the final handshake, then rd_busy = 0.
- Read of empty layer 4 -> no rd_valid, rd_done pulses on the cycle after rd_start.
- During RUN on layer 0 (len 2), 5 more layer-0 writes -> pass still ends after address 1. A new pass then reads addresses 0..6.
- clear asserted mid-RUN together with wr_valid -> wr_accept = 0, FSM in IDLE next cycle, no rd_done, all counters 0. wr_layer = 7 with NLAYERS = 6 -> ignored, no flag set.
